// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable and single-step controller: one-cycle cpu_ce pulses on the board clock
// for free run, debounced single step, N-pulse burst and run-to-breakpoint.
module cpu_step_ctrl #(
    parameter int DIV_W           = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BURST_W         = 8,
    parameter int ADDR_W          = 16,
    parameter int CNT_W           = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   div_sel,
    input  logic               button,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               cnt_clr,
    output logic               cpu_ce,
    output logic               halted,
    output logic [CNT_W-1:0]   ce_count
);

    localparam int PRE_W = (1 << DIV_W) - 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_BRK   = 2'b11;

    typedef enum logic [1:0] {S_HALT, S_RUN, S_BURST, S_BRK} state_t;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PRE_W:0]     tick_thr;
    logic               tick;
    logic [1:0]         sync_q, sync_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               btn_state_q, btn_state_d;
    logic               btn_prev_q, btn_prev_d;
    logic               press_q, press_d;
    logic [1:0]         mode_q;
    state_t             state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               first_q, first_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0]   ce_count_q, ce_count_d;

    // A >= compare (not ==) lets a div_sel decrease take effect without waiting for a wrap.
    assign tick_thr = ((PRE_W+1)'(1) << div_sel) - (PRE_W+1)'(1);
    assign tick     = ({1'b0, pre_q} >= tick_thr);

    // NOTE: every _d gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        pre_d       = tick ? '0 : pre_q + PRE_W'(1);
        sync_d      = {sync_q[0], button};
        btn_state_d = btn_state_q;
        db_cnt_d    = '0;
        if (sync_q[1] != btn_state_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))
                btn_state_d = sync_q[1];
            else
                db_cnt_d = db_cnt_q + DB_W'(1);
        end
        btn_prev_d = btn_state_q;
        press_d    = btn_prev_q & ~btn_state_q;

        state_d  = state_q;
        rem_d    = rem_q;
        first_d  = first_q;
        cpu_ce_d = 1'b0;
        if (mode != mode_q) begin
            state_d = (mode == MODE_RUN) ? S_RUN : S_HALT;
            rem_d   = '0;
            first_d = 1'b0;
        end else begin
            unique case (state_q)
                S_HALT: begin
                    unique case (mode)
                        MODE_RUN:   state_d = S_RUN;
                        MODE_STEP:  cpu_ce_d = press_q;
                        MODE_BURST: if (press_q && burst_len != '0) begin
                            rem_d   = burst_len;
                            state_d = S_BURST;
                        end
                        MODE_BRK:   if (press_q) begin
                            first_d = 1'b1;
                            state_d = S_BRK;
                        end
                    endcase
                end
                S_RUN: cpu_ce_d = tick;
                S_BURST: if (tick) begin
                    cpu_ce_d = 1'b1;
                    rem_d    = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1))
                        state_d = S_HALT;
                end
                S_BRK: if (tick) begin
                    // The first tick always steps so the CPU can leave a breakpoint it sits on.
                    if (first_q) begin
                        cpu_ce_d = 1'b1;
                        first_d  = 1'b0;
                    end else if (bp_en && pc == bp_addr) begin
                        state_d = S_HALT;
                    end else begin
                        cpu_ce_d = 1'b1;
                    end
                end
            endcase
        end

        ce_count_d = cnt_clr ? '0 : ce_count_q + CNT_W'(cpu_ce_q);
    end

    // Button idles high, so the synchroniser and debounced level reset to 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_q       <= '0;
            sync_q      <= 2'b11;
            db_cnt_q    <= '0;
            btn_state_q <= 1'b1;
            btn_prev_q  <= 1'b1;
            press_q     <= 1'b0;
            mode_q      <= MODE_STEP;
            state_q     <= S_HALT;
            rem_q       <= '0;
            first_q     <= 1'b0;
            cpu_ce_q    <= 1'b0;
            ce_count_q  <= '0;
        end else begin
            pre_q       <= pre_d;
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            btn_state_q <= btn_state_d;
            btn_prev_q  <= btn_prev_d;
            press_q     <= press_d;
            mode_q      <= mode;
            state_q     <= state_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            cpu_ce_q    <= cpu_ce_d;
            ce_count_q  <= ce_count_d;
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign halted   = (state_q == S_HALT);
    assign ce_count = ce_count_q;

endmodule
